// File: rtl/safe_softmax_pkg.sv
// Shared types and constants for the safe-softmax max-subtract stage.
package safe_softmax_pkg;

    localparam int unsigned D_W_DEF = 16;

    // Most negative representable difference for the default element width
    localparam logic [D_W_DEF-1:0] SAT_MIN = 16'h8000;

    typedef enum logic {
        LOAD  = 1'b0,
        DRAIN = 1'b1
    } state_e;

endpackage

// File: rtl/safe_softmax_row_buf.sv
// Row storage: one write port, one asynchronous read port, no reset on the array.
module safe_softmax_row_buf #(
    parameter int unsigned D_W     = 16,
    parameter int unsigned ROW_LEN = 16,
    parameter int unsigned AW      = 4
) (
    input  logic           i_clk,
    input  logic           i_we,
    input  logic [AW-1:0]  i_waddr,
    input  logic [D_W-1:0] i_wdata,
    input  logic [AW-1:0]  i_raddr,
    output logic [D_W-1:0] o_rdata
);

    logic [D_W-1:0] r_mem [ROW_LEN];

    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/safe_softmax_max_sub.sv
// Buffers one row of scores, tracks its signed maximum, then streams x_i - max.
// Optional macro SAFE_SOFTMAX_SAT_EN: saturate differences below the D_W range.
module safe_softmax_max_sub
    import safe_softmax_pkg::*;
#(
    parameter int unsigned D_W     = D_W_DEF,
    parameter int unsigned ROW_LEN = 16
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_valid,
    output logic           o_ready,
    input  logic [D_W-1:0] i_data,
    input  logic           i_last,
    output logic           o_valid,
    input  logic           i_ready,
    output logic [D_W-1:0] o_data,
    output logic           o_last,
    output logic [D_W-1:0] o_max
);

    localparam int unsigned AW = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;

    state_e         r_state;
    state_e         w_state_next;
    logic [AW-1:0]  r_cnt;
    logic [AW-1:0]  r_rd_ptr;
    logic [AW-1:0]  r_last_idx;
    logic [D_W-1:0] r_max;

    logic           w_in_xfer;
    logic           w_out_xfer;
    logic           w_is_first;
    logic           w_row_end;
    logic [D_W-1:0] w_max_next;
    logic [AW-1:0]  w_rd_addr;
    logic [D_W-1:0] w_rd_data;
    logic [D_W-1:0] w_x;
    logic [D_W-1:0] w_m;
    logic [D_W:0]   w_diff;
    logic [D_W-1:0] w_res;

    safe_softmax_row_buf #(
        .D_W     (D_W),
        .ROW_LEN (ROW_LEN),
        .AW      (AW)
    ) u_row_buf (
        .i_clk   (i_clk),
        .i_we    (w_in_xfer),
        .i_waddr (r_cnt),
        .i_wdata (i_data),
        .i_raddr (w_rd_addr),
        .o_rdata (w_rd_data)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= LOAD;
        else       r_state <= w_state_next;
    end

    // Next-state and transfer qualifiers
    always_comb begin
        w_state_next = r_state;
        w_in_xfer    = 1'b0;
        w_out_xfer   = 1'b0;
        w_is_first   = (r_cnt == '0);
        w_row_end    = 1'b0;
        case (r_state)
            LOAD: begin
                w_in_xfer = i_valid;
                w_row_end = i_valid && (i_last || (r_cnt == AW'(ROW_LEN - 1)));
                if (w_row_end) w_state_next = DRAIN;
            end
            DRAIN: begin
                w_out_xfer = o_valid && i_ready;
                if (w_out_xfer && o_last) w_state_next = LOAD;
            end
            default: w_state_next = LOAD;
        endcase
    end

    // Running max and the shared subtract path; in LOAD it forms element 0's result
    always_comb begin
        w_max_next = r_max;
        if (w_is_first || ($signed(i_data) > $signed(r_max))) w_max_next = i_data;
        w_rd_addr = (r_state == LOAD) ? '0 : r_rd_ptr;
        w_x       = ((r_state == LOAD) && w_is_first) ? i_data : w_rd_data;
        w_m       = (r_state == LOAD) ? w_max_next : o_max;
        w_diff    = {w_x[D_W-1], w_x} - {w_m[D_W-1], w_m};
`ifdef SAFE_SOFTMAX_SAT_EN
        if (w_diff[D_W] && !w_diff[D_W-1])
            w_res = (D_W == D_W_DEF) ? D_W'(SAT_MIN) : {1'b1, {(D_W-1){1'b0}}};
        else
            w_res = D_W'(w_diff);
`else
        w_res = D_W'(w_diff);
`endif
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_ready    <= 1'b1;
            o_valid    <= 1'b0;
            o_last     <= 1'b0;
            o_data     <= '0;
            o_max      <= '0;
            r_cnt      <= '0;
            r_rd_ptr   <= '0;
            r_last_idx <= '0;
            r_max      <= '0;
        end else begin
            o_ready <= (w_state_next == LOAD);
            if (w_in_xfer) begin
                r_cnt <= r_cnt + AW'(1);
                r_max <= w_max_next;
            end
            if (w_row_end) begin
                o_max      <= w_max_next;
                o_valid    <= 1'b1;
                o_data     <= w_res;
                o_last     <= w_is_first;
                r_rd_ptr   <= AW'(1);
                r_last_idx <= r_cnt;
            end else if (w_out_xfer) begin
                if (o_last) begin
                    o_valid  <= 1'b0;
                    o_last   <= 1'b0;
                    r_cnt    <= '0;
                    r_rd_ptr <= '0;
                end else begin
                    o_data   <= w_res;
                    o_last   <= (r_rd_ptr == r_last_idx);
                    r_rd_ptr <= r_rd_ptr + AW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_safe_softmax_max_sub.sv
// Randomized self-checking bench for safe_softmax_max_sub against a row-level reference model.
module tb_safe_softmax_max_sub;

    localparam int D_W     = 16;
    localparam int ROW_LEN = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic           i_valid;
    logic           o_ready;
    logic [D_W-1:0] i_data;
    logic           i_last;
    logic           o_valid;
    logic           i_ready;
    logic [D_W-1:0] o_data;
    logic           o_last;
    logic [D_W-1:0] o_max;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    safe_softmax_max_sub #(.D_W(D_W), .ROW_LEN(ROW_LEN)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_data  (i_data),
        .i_last  (i_last),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_data  (o_data),
        .o_last  (o_last),
        .o_max   (o_max)
    );

    function automatic logic [15:0] model_max(input logic [15:0] row[$]);
        int m = $signed(row[0]);
        foreach (row[i]) if (int'($signed(row[i])) > m) m = $signed(row[i]);
        return 16'(m);
    endfunction

    function automatic logic [15:0] model_diff(input logic [15:0] x, input logic [15:0] m);
        int d = int'($signed(x)) - int'($signed(m));
`ifdef SAFE_SOFTMAX_SAT_EN
        if (d < -32768) return 16'h8000;
`endif
        return 16'(d);
    endfunction

    // Drives one row, then drains it with the chosen ready pattern and records what came out.
    // mode 0: ready always high, 1: random ready, 2: ready low 3 cycles after the first output.
    task automatic drive_row(input logic [15:0] row[$], input bit use_last, input int mode,
                             output logic [15:0] outs[$], output bit lasts[$], output logic [15:0] mx,
                             output bit lat_ok, output int viol, output bit post_ok, output bit timeout);
        int  cyc = 0;
        int  stall_left = 3;
        bit  done = 0;
        bit  prev_hold = 0;
        bit  r;
        logic [15:0] pd;
        bit  pl;
        outs = {}; lasts = {}; viol = 0; timeout = 0; post_ok = 0;
        foreach (row[i]) begin
            @(negedge clk);
            if (!o_ready) viol++;
            i_valid = 1'b1;
            i_data  = row[i];
            i_last  = use_last && (i == row.size() - 1);
        end
        @(negedge clk);
        i_valid = 1'b0;
        i_last  = 1'b0;
        lat_ok  = o_valid;
        mx      = o_max;
        while (!done) begin
            if (prev_hold && (o_data !== pd || o_last !== pl || o_valid !== 1'b1)) viol++;
            if (o_ready !== 1'b0) viol++;
            if (o_max !== mx) viol++;
            case (mode)
                0:       r = 1'b1;
                1:       r = 1'($urandom_range(0, 1));
                default: begin
                    r = 1'b1;
                    if (outs.size() >= 1 && stall_left > 0) begin
                        r = 1'b0;
                        stall_left--;
                    end
                end
            endcase
            i_ready = r;
            if (o_valid && r) begin
                outs.push_back(o_data);
                lasts.push_back(o_last);
                if (o_last || outs.size() > 2 * ROW_LEN) done = 1;
            end
            prev_hold = o_valid && !r;
            pd = o_data;
            pl = o_last;
            @(negedge clk);
            cyc++;
            if (cyc > 200) begin
                timeout = 1;
                break;
            end
        end
        post_ok = !o_valid && o_ready;
        i_ready = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1; i_valid = 1'b0; i_data = '0; i_last = 1'b0; i_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL reset_o_valid got=%b exp=0", o_valid); end
        checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL reset_o_ready got=%b exp=1", o_ready); end
        checks++; if (o_last  !== 1'b0) begin failures++; $display("FAIL reset_o_last got=%b exp=0", o_last); end
        checks++; if (o_data  !== 16'h0) begin failures++; $display("FAIL reset_o_data got=%h exp=0000", o_data); end
        checks++; if (o_max   !== 16'h0) begin failures++; $display("FAIL reset_o_max got=%h exp=0000", o_max); end
        rst = 1'b0;
    endtask

    task automatic test_basic;
        logic [15:0] row[$] = '{16'h0100, 16'h0300, 16'h0200};
        logic [15:0] expd[3] = '{16'hFE00, 16'h0000, 16'hFF00};
        bit          expl[3] = '{1'b0, 1'b0, 1'b1};
        logic [15:0] outs[$]; bit lasts[$]; logic [15:0] mx; bit lat_ok, post_ok, to; int viol;
        drive_row(row, 1'b1, 0, outs, lasts, mx, lat_ok, viol, post_ok, to);
        checks++; if (!lat_ok) begin failures++; $display("FAIL basic_latency o_valid=0 exp=1"); end
        checks++; if (mx !== 16'h0300) begin failures++; $display("FAIL basic_max got=%h exp=0300", mx); end
        checks++; if (outs.size() != 3 || to) begin failures++; $display("FAIL basic_count got=%0d exp=3 timeout=%0b", outs.size(), to); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= outs.size() || outs[i] !== expd[i] || lasts[i] !== expl[i]) begin
                failures++;
                $display("FAIL basic_elem%0d got=%h/%b exp=%h/%b", i,
                         (i < outs.size()) ? outs[i] : 16'hxxxx, (i < lasts.size()) ? lasts[i] : 1'bx, expd[i], expl[i]);
            end
        end
        checks++; if (!post_ok) begin failures++; $display("FAIL basic_return o_valid=%b o_ready=%b exp=0/1", o_valid, o_ready); end
        checks++; if (viol != 0) begin failures++; $display("FAIL basic_handshake violations=%0d exp=0", viol); end
    endtask

    task automatic test_extremes;
        logic [15:0] row[$] = '{16'h8000, 16'h7FFF};
`ifdef SAFE_SOFTMAX_SAT_EN
        logic [15:0] e0 = 16'h8000;
`else
        logic [15:0] e0 = 16'h0001;
`endif
        logic [15:0] outs[$]; bit lasts[$]; logic [15:0] mx; bit lat_ok, post_ok, to; int viol;
        drive_row(row, 1'b1, 0, outs, lasts, mx, lat_ok, viol, post_ok, to);
        checks++; if (mx !== 16'h7FFF) begin failures++; $display("FAIL ext_max got=%h exp=7fff", mx); end
        checks++;
        if (outs.size() != 2 || outs[0] !== e0 || outs[1] !== 16'h0000 || lasts[1] !== 1'b1 || lasts[0] !== 1'b0) begin
            failures++;
            $display("FAIL ext_data n=%0d got0=%h got1=%h exp=%h/0000", outs.size(),
                     (outs.size() > 0) ? outs[0] : 16'hxxxx, (outs.size() > 1) ? outs[1] : 16'hxxxx, e0);
        end
    endtask

    task automatic check_row(input string name, input logic [15:0] row[$], input bit use_last, input int mode);
        logic [15:0] outs[$]; bit lasts[$]; logic [15:0] mx; bit lat_ok, post_ok, to; int viol;
        logic [15:0] em = model_max(row);
        int n = row.size();
        drive_row(row, use_last, mode, outs, lasts, mx, lat_ok, viol, post_ok, to);
        checks++; if (!lat_ok) begin failures++; $display("FAIL %s_latency o_valid=0 exp=1", name); end
        checks++; if (mx !== em) begin failures++; $display("FAIL %s_max got=%h exp=%h", name, mx, em); end
        checks++; if (outs.size() != n || to) begin failures++; $display("FAIL %s_count got=%0d exp=%0d timeout=%0b", name, outs.size(), n, to); end
        for (int i = 0; i < n && i < outs.size(); i++) begin
            checks++;
            if (outs[i] !== model_diff(row[i], em) || lasts[i] !== (i == n - 1)) begin
                failures++;
                $display("FAIL %s_elem%0d got=%h/%b exp=%h/%b", name, i, outs[i], lasts[i], model_diff(row[i], em), (i == n - 1));
            end
        end
        checks++; if (!post_ok) begin failures++; $display("FAIL %s_return o_valid=%b o_ready=%b exp=0/1", name, o_valid, o_ready); end
        checks++; if (viol != 0) begin failures++; $display("FAIL %s_handshake violations=%0d exp=0", name, viol); end
    endtask

    task automatic test_stall;
        logic [15:0] row[$];
        for (int i = 0; i < 6; i++) row.push_back(16'($urandom));
        check_row("stall", row, 1'b1, 2);
    endtask

    task automatic test_full_row;
        logic [15:0] row[$];
        for (int i = 0; i < ROW_LEN; i++) row.push_back(16'($urandom));
        check_row("full", row, 1'b0, 0);
    endtask

    task automatic test_reset_drain;
        logic [15:0] row[$] = '{16'h0010, 16'h0040, 16'h0020, 16'h0030};
        foreach (row[i]) begin
            @(negedge clk);
            i_valid = 1'b1; i_data = row[i]; i_last = (i == 3);
        end
        @(negedge clk);
        i_valid = 1'b0; i_last = 1'b0; i_ready = 1'b1;
        @(negedge clk);
        i_ready = 1'b0;
        rst = 1'b1;
        #1;
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL rstdrain_o_valid got=%b exp=0", o_valid); end
        checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL rstdrain_o_ready got=%b exp=1", o_ready); end
        @(negedge clk);
        rst = 1'b0;
        i_ready = 1'b1;
        check_row("single", '{16'h0005}, 1'b1, 0);
    endtask

    task automatic test_random;
        for (int r = 0; r < 25; r++) begin
            logic [15:0] row[$];
            int n = $urandom_range(1, ROW_LEN);
            bit narrow = 1'($urandom_range(0, 1));
            for (int i = 0; i < n; i++)
                row.push_back(narrow ? 16'($signed(5'($urandom))) : 16'($urandom));
            check_row("rand", row, (n < ROW_LEN) ? 1'b1 : 1'($urandom_range(0, 1)), 1);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_stall();
        test_full_row();
        test_reset_drain();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
